uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  8N1 UART receiver for the Sandpiper UART_RX pin. Replaces the template's RX->TX loopback with real byte reception.
//  Synchronises the pin, validates the start bit and samples each bit at mid-bit.
//  Delivers bytes to user logic through a one-entry valid/ready holding register.
//  Flags framing errors and overruns as one-cycle pulses.
// PARAMETERS
//  CLK_HZ        12000000  clock frequency in Hz (CLK_12MHZ)
//  BAUD          115200    line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 104 at defaults)
// PORTS
//  CLK_12MHZ     in   1  system clock, all logic on rising edge
//  RST           in   1  asynchronous, active-high reset
//  UART_RX       in   1  serial input, idle high, asynchronous to CLK_12MHZ
//  RX_DATA       out  8  received byte, stable while RX_VALID=1
//  RX_VALID      out  1  holding register full
//  RX_READY      in   1  consumer accepts; transfer when RX_VALID & RX_READY
//  FRAME_ERR     out  1  one-cycle pulse: stop bit sampled low
//  OVERRUN       out  1  one-cycle pulse: good frame dropped because the holding register was full
//  BUSY          out  1  state != IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - RX_DATA=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
//   - State IDLE; both synchroniser flops=1; counters=0.
//  Synchroniser: 2 flops; rxs = second flop; pin-to-rxs latency 2 cycles.
//  Counter: cnt, width clog2(CLKS_PER_BIT); bit index idx 0..7; shift register sr[7:0], LSB first.
//  FSM:
//   - IDLE: when rxs==0, go to START with cnt=0.
//   - START: count until cnt==CLKS_PER_BIT/2-1, then sample rxs.
//       rxs==0: go to DATA with cnt=0, idx=0.
//       rxs==1: glitch; go to IDLE with no flags.
//   - DATA: count until cnt==CLKS_PER_BIT-1, then sr={rxs,sr[7:1]}, cnt=0.
//       idx==7: go to STOP; otherwise idx+1.
//   - STOP: count until cnt==CLKS_PER_BIT-1, then sample rxs.
//       rxs==1: frame good; go to IDLE immediately (half stop bit early, allowing back-to-back frames).
//       rxs==0: FRAME_ERR pulse; data discarded; go to WAIT_HI.
//   - WAIT_HI: stay until rxs==1, then go to IDLE. A held-low line never restarts reception.
//  Holding register, evaluated on the cycle the frame is good:
//   - RX_VALID==0, or RX_VALID&RX_READY this cycle: RX_DATA<=sr, RX_VALID<=1 (next cycle). No overrun.
//   - RX_VALID==1 & RX_READY==0: keep old RX_DATA and RX_VALID=1; OVERRUN pulses for 1 cycle; new byte lost.
//   - Otherwise, RX_VALID&RX_READY clears RX_VALID the next cycle.
//  Latency:
//   - Good stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after IDLE sees rxs==0.
//   - RX_VALID rises on the following edge.
//  FRAME_ERR and OVERRUN are never asserted together.
//  RX_READY is ignored while RX_VALID==0.
//  Reset mid-frame aborts the frame; no flags are emitted.
// TESTING (CLK_HZ=12000000, BAUD=115200, CLKS_PER_BIT=104)
//  1. Send 0xA5 8N1, RX_READY=1.
//     -> RX_VALID=1 for exactly 1 cycle with RX_DATA=0xA5, 990+/-2 cycles after UART_RX falls.
//     -> BUSY low after the stop sample; no flags.
//  2. 30-cycle low glitch on an idle line.
//     -> Glitch rejected at cnt==51; no RX_VALID/FRAME_ERR; BUSY high for at most 54 cycles.
//  3. Frame 0x00 with the stop bit low, then the line held low for 500 cycles.
//     -> One FRAME_ERR pulse, no RX_VALID, BUSY stays high until the line returns high.
//     -> The next 0x5A frame is then received correctly.
//  4. Back-to-back 0x11, 0x22 with RX_READY=0.
//     -> RX_VALID=1, RX_DATA=0x11, one OVERRUN pulse at the second stop sample.
//     -> Then RX_READY=1 for 1 cycle -> RX_VALID=0.
//  5. Back-to-back 0x11, 0x22 with RX_READY pulsed exactly on the cycle of the second stop sample.
//     -> RX_DATA=0x22, RX_VALID stays 1, no OVERRUN.
//  6. Assert RST during data bit 3 of a frame.
//     -> All outputs 0 immediately.
//     -> After release and idle-high, a clean 0x3C frame gives RX_DATA=0x3C with no flags.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop pin synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_byte #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       CLK_12MHZ,
  input  logic       RST,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       sync_q;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       sr;

  // Pin synchroniser; resets to the idle-high line level.
  always_ff @(posedge CLK_12MHZ or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], UART_RX};
    end
  end

  assign rxs = sync_q[1];

  // Receive FSM together with the holding register and status pulses.
  always_ff @(posedge CLK_12MHZ or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sr        <= '0;
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            sr  <= {rxs, sr[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              // Leave half a stop bit early so a back-to-back start edge is seen.
              state <= IDLE;
              BUSY  <= 1'b0;
              if (!RX_VALID || RX_READY) begin
                RX_DATA  <= sr;
                RX_VALID <= 1'b1;
              end else begin
                OVERRUN <= 1'b1;
              end
            end else begin
              FRAME_ERR <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_HI: begin
          if (rxs) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus a random byte
// stream checked against a frame-level model of the receiver.
module tb_uart_rx_byte;

  localparam int unsigned CPB  = 12000000 / 115200;
  localparam int unsigned HALF = CPB / 2;
  // Edges from driving the start edge to the stop-bit sample: 2 sync + 1 detect + half + 9 bits.
  localparam int unsigned STOP_LAT = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int unsigned cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  int          n_valid = 0, n_ferr = 0, n_ovr = 0, n_both = 0, n_busy = 0;
  int unsigned last_rise = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  got[$];

  uart_rx_byte #(.CLK_HZ(12000000), .BAUD(115200)) dut (
    .CLK_12MHZ(clk),
    .RST(rst),
    .UART_RX(rx),
    .RX_DATA(rx_data),
    .RX_VALID(rx_valid),
    .RX_READY(rx_ready),
    .FRAME_ERR(frame_err),
    .OVERRUN(overrun),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid) n_valid++;
      if (rx_valid && !prev_valid) last_rise = cyc;
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (frame_err && overrun) n_both++;
      if (busy) n_busy++;
      prev_valid = rx_valid;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    idle(5);
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_single;
    int s_valid, s_ferr, s_ovr;
    int unsigned t0, lat;
    rx_ready = 1'b1;
    got.delete();
    s_valid = n_valid; s_ferr = n_ferr; s_ovr = n_ovr;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(50);
    lat = last_rise - t0;
    total_cnt++; if (got.size() != 1) $display("FAIL single_count: got %0d bytes want 1", got.size()); else pass_cnt++;
    total_cnt++; if (got.size() < 1 || got[0] !== 8'hA5) $display("FAIL single_data: got %h want a5", (got.size() > 0) ? got[0] : 8'hxx); else pass_cnt++;
    total_cnt++; if (n_valid - s_valid != 1) $display("FAIL single_valid_len: got %0d cycles want 1", n_valid - s_valid); else pass_cnt++;
    total_cnt++; if (lat < STOP_LAT - 3 || lat > STOP_LAT + 1) $display("FAIL single_latency: got %0d want 990+/-2", lat); else pass_cnt++;
    total_cnt++; if (n_ferr != s_ferr || n_ovr != s_ovr) $display("FAIL single_flags: got ferr %0d ovr %0d want 0 0", n_ferr - s_ferr, n_ovr - s_ovr); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int s_valid, s_ferr, s_busy;
    s_valid = n_valid; s_ferr = n_ferr; s_busy = n_busy;
    rx = 1'b0;
    idle(30);
    rx = 1'b1;
    idle(200);
    total_cnt++; if (n_busy - s_busy < 1 || n_busy - s_busy > 54) $display("FAIL glitch_busy: got %0d cycles want 1..54", n_busy - s_busy); else pass_cnt++;
    total_cnt++; if (n_valid != s_valid || n_ferr != s_ferr) $display("FAIL glitch_flags: got valid %0d ferr %0d want 0 0", n_valid - s_valid, n_ferr - s_ferr); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int s_valid, s_ferr;
    rx_ready = 1'b1;
    got.delete();
    s_valid = n_valid; s_ferr = n_ferr;
    send_frame(8'h00, 1'b0);
    idle(500);
    total_cnt++; if (busy !== 1'b1) $display("FAIL ferr_busy_low_line: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (n_ferr - s_ferr != 1) $display("FAIL ferr_pulses: got %0d want 1", n_ferr - s_ferr); else pass_cnt++;
    total_cnt++; if (n_valid != s_valid) $display("FAIL ferr_no_valid: got %0d valid cycles want 0", n_valid - s_valid); else pass_cnt++;
    rx = 1'b1;
    idle(10);
    total_cnt++; if (busy !== 1'b0) $display("FAIL ferr_busy_release: got %b want 0", busy); else pass_cnt++;
    send_frame(8'h5A, 1'b1);
    idle(50);
    total_cnt++; if (got.size() != 1 || got[0] !== 8'h5A) $display("FAIL ferr_recover: got %0d bytes first %h want 1 byte 5a", got.size(), (got.size() > 0) ? got[0] : 8'hxx); else pass_cnt++;
  endtask

  task automatic test_overrun;
    int s_ovr, s_ferr;
    rx_ready = 1'b0;
    got.delete();
    s_ovr = n_ovr; s_ferr = n_ferr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", rx_valid); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h11) $display("FAIL ovr_data_kept: got %h want 11", rx_data); else pass_cnt++;
    total_cnt++; if (n_ovr - s_ovr != 1) $display("FAIL ovr_pulses: got %0d want 1", n_ovr - s_ovr); else pass_cnt++;
    total_cnt++; if (n_ferr != s_ferr || n_both != 0) $display("FAIL ovr_other_flags: got ferr %0d both %0d want 0 0", n_ferr - s_ferr, n_both); else pass_cnt++;
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_drain: got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++; if (got.size() != 1 || got[0] !== 8'h11) $display("FAIL ovr_accepted: got %0d bytes first %h want 1 byte 11", got.size(), (got.size() > 0) ? got[0] : 8'hxx); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int s_ovr;
    rx_ready = 1'b0;
    got.delete();
    s_ovr = n_ovr;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        idle(10 * CPB + STOP_LAT - 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(20);
    total_cnt++; if (rx_data !== 8'h22) $display("FAIL b2b_data: got %h want 22", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", rx_valid); else pass_cnt++;
    total_cnt++; if (n_ovr != s_ovr) $display("FAIL b2b_no_overrun: got %0d want 0", n_ovr - s_ovr); else pass_cnt++;
    total_cnt++; if (got.size() != 1 || got[0] !== 8'h11) $display("FAIL b2b_first_taken: got %0d bytes first %h want 1 byte 11", got.size(), (got.size() > 0) ? got[0] : 8'hxx); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    int s_valid, s_ferr, s_ovr;
    logic [7:0] b;
    b = 8'($urandom);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = b[3];
    idle(HALF);
    rst = 1'b1;
    #1;
    total_cnt++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) $display("FAIL midrst_hold: got data %h valid %b want 00 0", rx_data, rx_valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_status: got ferr %b ovr %b busy %b want 0 0 0", frame_err, overrun, busy); else pass_cnt++;
    rx = 1'b1;
    idle(5);
    rst = 1'b0;
    s_valid = n_valid; s_ferr = n_ferr; s_ovr = n_ovr;
    idle(200);
    total_cnt++; if (busy !== 1'b0 || n_valid != s_valid || n_ferr != s_ferr || n_ovr != s_ovr) $display("FAIL midrst_quiet: got busy %b valid %0d ferr %0d ovr %0d want all 0", busy, n_valid - s_valid, n_ferr - s_ferr, n_ovr - s_ovr); else pass_cnt++;
    rx_ready = 1'b1;
    got.delete();
    send_frame(8'h3C, 1'b1);
    idle(50);
    total_cnt++; if (got.size() != 1 || got[0] !== 8'h3C) $display("FAIL midrst_recover: got %0d bytes first %h want 1 byte 3c", got.size(), (got.size() > 0) ? got[0] : 8'hxx); else pass_cnt++;
    total_cnt++; if (n_ferr != s_ferr || n_ovr != s_ovr) $display("FAIL midrst_recover_flags: got ferr %0d ovr %0d want 0 0", n_ferr - s_ferr, n_ovr - s_ovr); else pass_cnt++;
  endtask

  task automatic test_random_stream;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int s_ferr, s_ovr;
    rx_ready = 1'b1;
    got.delete();
    s_ferr = n_ferr; s_ovr = n_ovr;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      idle(1 + int'($urandom_range(0, 40)));
    end
    idle(100);
    total_cnt++; if (got.size() != exp_q.size()) $display("FAIL rand_count: got %0d bytes want %0d", got.size(), exp_q.size()); else pass_cnt++;
    for (int n = 0; n < exp_q.size(); n++) begin
      total_cnt++;
      if (n >= got.size() || got[n] !== exp_q[n]) $display("FAIL rand_byte%0d: got %h want %h", n, (n < got.size()) ? got[n] : 8'hxx, exp_q[n]);
      else pass_cnt++;
    end
    total_cnt++; if (n_ferr != s_ferr || n_ovr != s_ovr || n_both != 0) $display("FAIL rand_flags: got ferr %0d ovr %0d both %0d want 0 0 0", n_ferr - s_ferr, n_ovr - s_ovr, n_both); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
